// File: rtl/bram_seq_pkg.sv
// -----------------------------------------------------------------------------
// bram_seq_pkg -- shared definitions for the serial BRAM sequencer.
//   * op encoding of the command frame {op, addr, data}
//   * controller state enumeration
//   * cmd_width(): command frame width derived from address/data widths
// No ports (package).
// -----------------------------------------------------------------------------
package bram_seq_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_CAPT  = 3'd4,
    ST_FILL     = 3'd5
  } state_t;

  // Frame = 2 op bits + address + data.
  function automatic int cmd_width(input int addr_w, input int data_w);
    return 2 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/bram_seq_shr.sv
// -----------------------------------------------------------------------------
// bram_seq_shr -- generic W-bit shift register.
//   Serial-in/parallel-out when load=0 (sin enters at LSB, bits move to MSB),
//   parallel-load/serial-out when load=1 (read the MSB of q as the serial out).
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset, clears q
//   load   in  1  parallel load enable (priority over shifting)
//   sin    in  1  serial input bit
//   pdata  in  W  parallel load data
//   q      out W  register contents
// -----------------------------------------------------------------------------
module bram_seq_shr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         sin,
  input  logic [W-1:0] pdata,
  output logic [W-1:0] q
);

  // Shift every cycle unless a parallel load is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (load) begin
      q <= pdata;
    end else begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/bram_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bram_seq_ctrl -- serial command sequencer for a single-port block RAM.
// A frame {op[1:0], addr, data} is shifted in on di (MSB first) and executed
// when stb is seen in IDLE: NOP (clear err), WRITE, READ (result shifted out
// on dout, MSB first) or FILL (write data from addr up to the top address).
// Optional macro BRAM_SEQ_CTRL_OUTREG_EN: RAM has an output register, adding
// an RD_WAIT cycle with ram_regce=1; otherwise ram_regce is tied low.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   di, stb            serial command bit, command strobe
//   dout               serial read data (the name "do" is a reserved word)
//   busy, done, err    not idle, one-cycle completion pulse, sticky error
//   ram_en, ram_we, ram_regce, ram_addr, ram_din  RAM control/data out
//   ram_dout           RAM read data in
// -----------------------------------------------------------------------------
module bram_seq_ctrl
  import bram_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              di,
  input  logic              stb,
  output logic              dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_regce,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [CMD_W-1:0]  cmd_q;
  logic [DATA_W-1:0] out_q;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              capture;

  state_t            state_r, state_n;
  logic              busy_r, busy_n, done_r, done_n, err_r, err_n;
  logic              en_r, en_n, we_r, we_n, do_r;
  logic [ADDR_W-1:0] addr_r, addr_n;
  logic [DATA_W-1:0] din_r, din_n;
`ifdef BRAM_SEQ_CTRL_OUTREG_EN
  logic              regce_r, regce_n;
`endif

  // The frame is the register content before this cycle's shift.
  assign cmd_op   = cmd_q[CMD_W-1 -: 2];
  assign cmd_addr = cmd_q[DATA_W +: ADDR_W];
  assign cmd_data = cmd_q[DATA_W-1:0];
  assign capture  = (state_r == ST_RD_CAPT);

  bram_seq_shr #(.W(CMD_W)) u_cmd (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .sin(di),
    .pdata({CMD_W{1'b0}}), .q(cmd_q)
  );

  bram_seq_shr #(.W(DATA_W)) u_out (
    .clk(clk), .rst_n(rst_n), .load(capture), .sin(1'b0),
    .pdata(ram_dout), .q(out_q)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_n = state_r;
    done_n  = 1'b0;
    err_n   = err_r;
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = addr_r;
    din_n   = din_r;
`ifdef BRAM_SEQ_CTRL_OUTREG_EN
    regce_n = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (stb) begin
          case (cmd_op)
            OP_NOP: begin
              done_n = 1'b1;
              err_n  = 1'b0;
            end
            OP_WRITE: begin
              state_n = ST_WRITE;
              en_n    = 1'b1;
              we_n    = 1'b1;
              addr_n  = cmd_addr;
              din_n   = cmd_data;
            end
            OP_READ: begin
              state_n = ST_RD_ISSUE;
              en_n    = 1'b1;
              addr_n  = cmd_addr;
            end
            OP_FILL: begin
              state_n = ST_FILL;
              en_n    = 1'b1;
              we_n    = 1'b1;
              addr_n  = cmd_addr;
              din_n   = cmd_data;
            end
            default: state_n = ST_IDLE;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      ST_RD_ISSUE: begin
`ifdef BRAM_SEQ_CTRL_OUTREG_EN
        state_n = ST_RD_WAIT;
        regce_n = 1'b1;
`else
        state_n = ST_RD_CAPT;
`endif
      end
      ST_RD_WAIT: state_n = ST_RD_CAPT;
      ST_RD_CAPT: begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
      ST_FILL: begin
        // Stop after the top address; the counter never wraps to zero.
        if (addr_r == ADDR_TOP) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          addr_n = addr_r + ADDR_ONE;
          en_n   = 1'b1;
          we_n   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A strobe while busy is dropped but remembered as an error.
    if (stb && (state_r != ST_IDLE)) begin
      err_n = 1'b1;
    end else begin
      err_n = err_n;
    end
    busy_n = (state_n != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      en_r    <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      din_r   <= {DATA_W{1'b0}};
      do_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      err_r   <= err_n;
      en_r    <= en_n;
      we_r    <= we_n;
      addr_r  <= addr_n;
      din_r   <= din_n;
      do_r    <= out_q[DATA_W-1];
    end
  end

`ifdef BRAM_SEQ_CTRL_OUTREG_EN
  // Output-register clock enable for the RAM, high during RD_WAIT only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regce_r <= 1'b0;
    end else begin
      regce_r <= regce_n;
    end
  end
  assign ram_regce = regce_r;
`else
  assign ram_regce = 1'b0;
`endif

  assign dout     = do_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign ram_en   = en_r;
  assign ram_we   = we_r;
  assign ram_addr = addr_r;
  assign ram_din  = din_r;

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_seq_ctrl -- self-checking bench for bram_seq_ctrl (ADDR_W=10,
// DATA_W=8). A behavioural RAM is attached; expected activity per cycle after
// each strobe is derived from the command rules and a reference memory image.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bram_seq_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int CW = 2 + AW + DW;
  localparam int DEPTH = 1 << AW;
`ifdef BRAM_SEQ_CTRL_OUTREG_EN
  localparam int  RD_LAT = 4;
  localparam bit  OUTREG = 1'b1;
`else
  localparam int  RD_LAT = 3;
  localparam bit  OUTREG = 1'b0;
`endif
  localparam logic [1:0] NOP = 2'b00, WR = 2'b01, RD = 2'b10, FL = 2'b11;

  logic clk = 1'b0, rst_n = 1'b0, di = 1'b0, stb = 1'b0;
  logic dout, busy, done, err, ram_en, ram_we, ram_regce;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout, rd_lat, rd_oreg;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int  total = 0, bad = 0;
  bit  err_model = 1'b0;

  bram_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .di(di), .stb(stb), .dout(dout), .busy(busy),
    .done(done), .err(err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_regce(ram_regce), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with optional output register.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        rd_lat <= ram_mem[ram_addr];
    end
    if (ram_regce) rd_oreg <= rd_lat;
  end
  assign ram_dout = OUTREG ? rd_oreg : rd_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shift a frame MSB first, then raise stb for one cycle (cycle 0).
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [CW-1:0] f;
    f = {op, a, d};
    for (int i = CW - 1; i >= 0; i--) begin
      @(posedge clk); #1;
      di  = f[i];
      stb = 1'b0;
    end
    @(posedge clk); #1;
    stb = 1'b1;
    di  = 1'($urandom);
  endtask

  // Issue one command and check every cycle until it (and any read stream) ends.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int stb_at);
    int done_n, nwr, last;
    logic [DW-1:0] rbyte;
    logic exp_en, exp_we, exp_do;
    nwr    = (op == FL) ? (DEPTH - int'(a)) : ((op == WR) ? 1 : 0);
    done_n = (op == NOP) ? 1 : (op == WR) ? 2 : (op == RD) ? RD_LAT : nwr + 1;
    last   = (op == RD) ? RD_LAT + DW + 2 : done_n + 1;
    rbyte  = ref_mem[a];
    send(op, a, d);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      stb = (n == stb_at);
      di  = 1'($urandom);
      @(negedge clk);
      exp_we = (n <= nwr);
      exp_en = exp_we || (op == RD && n == 1);
      chk("ram_en", ram_en, exp_en);
      chk("ram_we", ram_we, exp_we);
      if (exp_en) chk("ram_addr", ram_addr, a + AW'(n - 1));
      if (exp_we) begin
        chk("ram_din", ram_din, d);
        ref_mem[a + AW'(n - 1)] = d;
      end
      chk("ram_regce", ram_regce, OUTREG && op == RD && n == 2);
      chk("done", done, n == done_n);
      chk("busy", busy, n < done_n);
      if (op == NOP) err_model = 1'b0;
      if (stb_at > 0 && n > stb_at) err_model = 1'b1;
      chk("err", err, err_model);
      exp_do = (op == RD && n > RD_LAT && n <= RD_LAT + DW) ? rbyte[DW - (n - RD_LAT)] : 1'b0;
      chk("do", dout, exp_do);
    end
    stb = 1'b0;
  endtask

  initial begin
    logic [1:0]    op;
    logic [AW-1:0] a;
    int            sa;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = DW'($urandom);
      ram_mem[i] = ref_mem[i];
    end
    ref_mem[5] = 8'h00;
    ram_mem[5] = 8'h00;

    // Reset state.
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_do", dout, 1'b0);
    chk("rst_ctl", {ram_en, ram_we, ram_regce}, 3'b000);
    chk("rst_addr", ram_addr, 10'h000);
    chk("rst_din", ram_din, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: write, read back, fill at top, strobe during fill, NOP.
    run_cmd(WR, 10'h005, 8'hA5, 0);
    run_cmd(RD, 10'h005, 8'h00, 0);
    run_cmd(FL, 10'h3FC, 8'h3C, 0);
    run_cmd(RD, 10'h3FF, 8'h00, 0);
    run_cmd(FL, 10'h3FF, 8'h77, 0);
    run_cmd(FL, 10'h3F0, 8'h11, 3);
    run_cmd(RD, 10'h3F4, 8'h00, 0);
    run_cmd(NOP, 10'h000, 8'h00, 0);

    // Reset in the second FILL cycle aborts the fill immediately.
    send(FL, 10'h3E0, 8'h5A);
    @(posedge clk); #1;
    stb = 1'b0;
    @(negedge clk);
    chk("fill1_addr", ram_addr, 10'h3E0);
    ref_mem[10'h3E0] = 8'h5A;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {ram_en, ram_we, ram_regce, busy, done, err, dout}, 7'd0);
    chk("arst_addr", ram_addr, 10'h000);
    chk("arst_din", ram_din, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_en", ram_en, 1'b0);
    end
    rst_n = 1'b1;
    err_model = 1'b0;
    run_cmd(WR, 10'h123, 8'hC3, 0);
    run_cmd(RD, 10'h123, 8'h00, 0);
    run_cmd(RD, 10'h3E1, 8'h00, 0);

    // Randomized commands.
    for (int t = 0; t < 30; t++) begin
      op = 2'($urandom);
      a  = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 4'($urandom)};
      sa = 0;
      if (op == FL) begin
        a = {5'h1F, 5'($urandom)};
        if (a <= 10'h3FD && $urandom_range(0, 1) == 1) sa = 2;
      end
      run_cmd(op, a, DW'($urandom), sa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time guard.
  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/bram_seq_ctrl.md
BRAM_SEQ_CTRL -- requirements
Module: bram_seq_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning RAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, meaning RAM data width in bits; command frame width CMD_W = 2+ADDR_W+DATA_W.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports di input 1 (serial command bit) and stb input 1 (command strobe).
REQ-006 SHALL have ports do output 1 (serial read data), busy output 1, done output 1 (one-cycle pulse), err output 1 (sticky).
REQ-007 SHALL have RAM port signals: ram_en out 1, ram_we out 1, ram_regce out 1, ram_addr out ADDR_W, ram_din out DATA_W, ram_dout in DATA_W.

Function
REQ-008 SHALL shift di into a CMD_W-bit command register every cycle: new bit at LSB, existing bits move toward MSB, regardless of state.
REQ-009 SHALL decode the frame as {op[1:0], addr[ADDR_W-1:0], data[DATA_W-1:0]}, MSB first; op 00=NOP, 01=WRITE, 10=READ, 11=FILL.
REQ-010 SHALL latch the frame when stb=1 in IDLE. The latched frame is the command register contents before that cycle's shift.
REQ-011 SHALL implement states IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_CAPT, FILL; busy=1 in every state except IDLE.
REQ-012 NOP: SHALL clear err and pulse done in the cycle after stb, staying in IDLE.
REQ-013 WRITE: SHALL assert ram_en=ram_we=1 with latched addr and data for exactly one cycle, then pulse done and return to IDLE.
REQ-014 READ: RD_ISSUE SHALL drive ram_en=1, ram_we=0 and addr for one cycle.
REQ-015 READ: RD_CAPT SHALL load ram_dout into a DATA_W-bit output shift register, pulse done and return to IDLE.
REQ-016 SHALL present the output shift register MSB on do and shift it left every cycle, filling with 0; after DATA_W cycles do=0 until the next capture.
REQ-017 FILL: SHALL write data at consecutive addresses from addr up to 2^ADDR_W-1, one per cycle with ram_en=ram_we=1; after the write at the all-ones address it SHALL pulse done and return to IDLE, with no wrap-around.
REQ-018 FILL with addr = all-ones SHALL perform exactly one write.
REQ-019 stb=1 while busy=1 SHALL be ignored and SHALL set err; err stays set until a NOP completes or reset.
REQ-020 ram_en, ram_we and ram_regce SHALL be 0 in IDLE; ram_addr and ram_din hold their last values.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE and drive busy, done, err, do, ram_en, ram_we and ram_regce to 0, and ram_addr, ram_din and all shift registers to 0.
REQ-022 Reset asserted mid-command SHALL abort the command with no done pulse; the first stb after release is accepted.

Configuration
REQ-023 Macro BRAM_SEQ_CTRL_OUTREG_EN SHALL select the RAM output-register timing.
REQ-024 With BRAM_SEQ_CTRL_OUTREG_EN defined: RD_WAIT SHALL last one cycle with ram_regce=1, giving capture 2 cycles after issue (stb to done = 4 cycles).
REQ-025 Without BRAM_SEQ_CTRL_OUTREG_EN: RD_WAIT SHALL be skipped and ram_regce tied 0, giving capture 1 cycle after issue (stb to done = 3 cycles).

Structure
REQ-026 Package bram_seq_pkg SHALL hold the op encoding constants, the state enumeration and the CMD_W derivation function.
REQ-027 Sub-module bram_seq_shr (parametric width, serial-in/parallel-out and parallel-load/serial-out shift register) SHALL be used for both the command and output registers.

Verification
REQ-028 Shift a WRITE frame with addr=0x005 and data=0xA5, then strobe -> exactly one cycle with ram_en=ram_we=1, ram_addr=0x005, ram_din=0xA5; done at stb+2.
REQ-029 READ addr=0x005 with RAM model returning 0xA5 -> do emits 1,0,1,0,0,1,0,1 on consecutive cycles starting the cycle after done, then 0.
REQ-030 FILL addr=0x3FC, data=0x3C -> writes at 0x3FC, 0x3FD, 0x3FE and 0x3FF only; single done pulse; never address 0x000.
REQ-031 stb during FILL -> command ignored and err=1; a following NOP -> err=0 and done pulse.
REQ-032 rst_n low in the 2nd FILL cycle -> all outputs 0 asynchronously with no further writes; a WRITE after release executes normally.
REQ-033 Run REQ-029 both with and without BRAM_SEQ_CTRL_OUTREG_EN -> stb-to-done latency of 4 and 3 cycles respectively.
